rr_issue_arbiter: RTL

// - Shares one downstream consumer (functional unit / writeback port) between N_REQ producers (reservation stations).
// - Picks one valid requester per cycle in round-robin order and latches its payload into a single-entry output register.
// - Presents the entry to the consumer with a valid/ready handshake.
// - Flushes the held entry on mispredict.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 38 +++
 rtl/rr_issue_arbiter.sv | 69 ++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin issue arbiter: index sizing and pointer wrap.
package arb_pkg;

  localparam int MIN_IDX_W = 1;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : MIN_IDX_W;
  endfunction

  // Next round-robin position, wrapping explicitly so non-power-of-2 counts never overflow.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr wins.
module rr_priority_picker
  import arb_pkg::*;
#(
  parameter  int N_REQ = 3,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [N_REQ-1:0] window;
  int               sel;

  // NOTE: every output gets a default before the loop so no path leaves a latch behind.
  always_comb begin
    window    = N_REQ'({req_valid, req_valid} >> rr_ptr);
    sel       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    // Scan downwards so the lowest rotated offset (closest to rr_ptr) is the last write.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (window[k]) begin
        sel = int'(rr_ptr) + k;
        if (sel >= N_REQ) sel = sel - N_REQ;
        grant      = '0;
        grant[sel] = 1'b1;
        grant_idx  = IDX_W'(sel);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_issue_arbiter.sv
// Round-robin issue arbiter: N_REQ producers share one single-entry valid/ready output register.
module rr_issue_arbiter
  import arb_pkg::*;
#(
  parameter  type T     = logic,
  parameter  int  N_REQ = 3,
  localparam int  IDX_W = idx_width(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mispredict,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  T                 req_data [N_REQ],
  output logic             out_valid,
  input  logic             out_ready,
  output T                 out_data,
  output logic [IDX_W-1:0] out_src
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q;
  T                 out_data_q;
  logic [IDX_W-1:0] out_src_q;

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any_grant;
  logic             slot_free;
  logic             accept;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // The slot can refill in the same cycle the consumer drains it.
  assign slot_free = !out_valid_q || out_ready;
  assign accept    = any_grant && slot_free && !mispredict && !reset;
  assign req_ready = accept ? grant : '0;
  assign rr_ptr_d  = IDX_W'(rr_next(int'(grant_idx), N_REQ));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (mispredict) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= req_data[grant_idx];
      out_src_q   <= grant_idx;
      rr_ptr_q    <= rr_ptr_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
